// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ex_muldiv_pkg
// Brief    : Operation/result-class encodings and divider state type for EX.
// Revision : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

    localparam logic c_reset_enable = 1'b1;

    // aluop encodings
    localparam logic [7:0] c_op_nop   = 8'b0000_0000;
    localparam logic [7:0] c_op_and   = 8'b0010_0100;
    localparam logic [7:0] c_op_or    = 8'b0010_0101;
    localparam logic [7:0] c_op_xor   = 8'b0010_0110;
    localparam logic [7:0] c_op_nor   = 8'b0010_0111;
    localparam logic [7:0] c_op_sll   = 8'b0111_1100;
    localparam logic [7:0] c_op_srl   = 8'b0000_0010;
    localparam logic [7:0] c_op_sra   = 8'b0000_0011;
    localparam logic [7:0] c_op_add   = 8'b0010_0000;
    localparam logic [7:0] c_op_sub   = 8'b0010_0010;
    localparam logic [7:0] c_op_slt   = 8'b0010_1010;
    localparam logic [7:0] c_op_sltu  = 8'b0010_1011;
    localparam logic [7:0] c_op_mfhi  = 8'b0001_0000;
    localparam logic [7:0] c_op_mthi  = 8'b0001_0001;
    localparam logic [7:0] c_op_mflo  = 8'b0001_0010;
    localparam logic [7:0] c_op_mtlo  = 8'b0001_0011;
    localparam logic [7:0] c_op_mult  = 8'b0001_1000;
    localparam logic [7:0] c_op_multu = 8'b0001_1001;
    localparam logic [7:0] c_op_div   = 8'b0001_1010;
    localparam logic [7:0] c_op_divu  = 8'b0001_1011;

    // alusel result classes
    localparam logic [2:0] c_sel_nop   = 3'b000;
    localparam logic [2:0] c_sel_logic = 3'b001;
    localparam logic [2:0] c_sel_shift = 3'b010;
    localparam logic [2:0] c_sel_move  = 3'b011;
    localparam logic [2:0] c_sel_arith = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_div_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : div_seq
// Brief    : Iterative radix-2 restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int CW = $clog2(DATA_W) + 1;

    div_state_e        r_state;
    div_state_e        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_dvs_zero;

    assign w_abs_a    = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
    assign w_abs_b    = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;
    assign w_dvs_zero = (divisor_i == '0);

    // The dividend register doubles as the quotient: its MSB shifts into the
    // partial remainder while the new quotient bit enters at the LSB.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (start_i) w_state_nxt = w_dvs_zero ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (r_cnt == CW'(DATA_W - 1)) w_state_nxt = DIV_DONE;
            DIV_DONE: w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (annul_i) w_state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst == c_reset_enable) r_state <= DIV_IDLE;
        else                       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst == c_reset_enable) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == DIV_IDLE && start_i && !annul_i) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dvs_zero ? '0 : w_abs_a;
            r_dvs   <= w_abs_b;
            r_neg_q <= !w_dvs_zero && signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            r_neg_r <= !w_dvs_zero && signed_i && dividend_i[DATA_W-1];
        end else if (r_state == DIV_CALC && !annul_i) begin
            r_cnt <= r_cnt + CW'(1);
            if (!w_diff[DATA_W]) begin
                r_rem <= w_diff[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign ready_o     = (r_state == DIV_DONE);
    assign quotient_o  = r_neg_q ? -r_quo : r_quo;
    assign remainder_o = r_neg_r ? -r_rem : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ex_muldiv
// Brief    : Execute stage: logic/shift/arith/move results, MULT and iterative DIV.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [SEL_W-1:0]  alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic                w_op_div;
    logic                w_op_divu;
    logic                w_is_div;
    logic                w_op_mult;
    logic                w_op_multu;
    logic                w_div_ready;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic [SH_W-1:0]     w_shamt;
    logic [2*DATA_W-1:0] w_mul_a;
    logic [2*DATA_W-1:0] w_mul_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_logic_res;
    logic [DATA_W-1:0]   w_shift_res;
    logic [DATA_W-1:0]   w_arith_res;
    logic [DATA_W-1:0]   w_move_res;

    assign w_op_div   = (aluop_i == OP_W'(c_op_div));
    assign w_op_divu  = (aluop_i == OP_W'(c_op_divu));
    assign w_is_div   = w_op_div | w_op_divu;
    assign w_op_mult  = (aluop_i == OP_W'(c_op_mult));
    assign w_op_multu = (aluop_i == OP_W'(c_op_multu));
    assign w_shamt    = reg1_i[SH_W-1:0];

    // One 2W-bit multiplier serves both MULT and MULTU: sign-extending the
    // operands for MULT makes the low 2W bits the signed product.
    assign w_mul_a = {{DATA_W{w_op_mult & reg1_i[DATA_W-1]}}, reg1_i};
    assign w_mul_b = {{DATA_W{w_op_mult & reg2_i[DATA_W-1]}}, reg2_i};
    assign w_prod  = w_mul_a * w_mul_b;

    div_seq #(
        .DATA_W (DATA_W)
    ) u_div_seq (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_is_div & ~flush_i),
        .annul_i     (flush_i),
        .signed_i    (w_op_div),
        .dividend_i  (reg1_i),
        .divisor_i   (reg2_i),
        .ready_o     (w_div_ready),
        .quotient_o  (w_quo),
        .remainder_o (w_rem)
    );

    always_comb begin
        w_logic_res = '0;
        w_shift_res = '0;
        w_arith_res = '0;
        w_move_res  = '0;
        case (aluop_i)
            OP_W'(c_op_or):   w_logic_res = reg1_i | reg2_i;
            OP_W'(c_op_and):  w_logic_res = reg1_i & reg2_i;
            OP_W'(c_op_xor):  w_logic_res = reg1_i ^ reg2_i;
            OP_W'(c_op_nor):  w_logic_res = ~(reg1_i | reg2_i);
            OP_W'(c_op_sll):  w_shift_res = reg2_i << w_shamt;
            OP_W'(c_op_srl):  w_shift_res = reg2_i >> w_shamt;
            OP_W'(c_op_sra):  w_shift_res = $signed(reg2_i) >>> w_shamt;
            OP_W'(c_op_add):  w_arith_res = reg1_i + reg2_i;
            OP_W'(c_op_sub):  w_arith_res = reg1_i - reg2_i;
            OP_W'(c_op_slt):  w_arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            OP_W'(c_op_sltu): w_arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            OP_W'(c_op_mfhi): w_move_res  = hi_i;
            OP_W'(c_op_mflo): w_move_res  = lo_i;
            default: ;
        endcase
    end

    always_comb begin
        wdata_o    = '0;
        wd_o       = '0;
        wreg_o     = 1'b0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (rst != c_reset_enable) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
            case (alusel_i)
                SEL_W'(c_sel_logic): wdata_o = w_logic_res;
                SEL_W'(c_sel_shift): wdata_o = w_shift_res;
                SEL_W'(c_sel_arith): wdata_o = w_arith_res;
                SEL_W'(c_sel_move):  wdata_o = w_move_res;
                default:             wdata_o = '0;
            endcase
            if (aluop_i == OP_W'(c_op_mthi)) begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end else if (aluop_i == OP_W'(c_op_mtlo)) begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end else if (w_op_mult || w_op_multu) begin
                whilo_o = 1'b1;
                {hi_o, lo_o} = w_prod;
            end else if (w_is_div && w_div_ready) begin
                whilo_o = 1'b1;
                hi_o    = w_rem;
                lo_o    = w_quo;
            end
            // An annulled instruction must never reach HI/LO or hold the pipe.
            if (flush_i) whilo_o = 1'b0;
            stallreq_o = w_is_div & ~w_div_ready & ~flush_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Randomised scoreboard bench for ex_muldiv against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   aluop = '0;
    logic [2:0]   alusel = '0;
    logic [W-1:0] reg1 = '0, reg2 = '0, hi_in = '0, lo_in = '0;
    logic [4:0]   wd = '0;
    logic         wreg = 1'b0, flush = 1'b0;
    logic [W-1:0] wdata_o, hi_o, lo_o;
    logic [4:0]   wd_o;
    logic         wreg_o, whilo_o, stallreq_o;

    typedef struct {
        logic [W-1:0] wdata;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [4:0]   wd;
        logic         wreg;
        logic         whilo;
        int           stalls;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   stall_run = 0;
    bit   done = 1'b0;
    bit   to_flag = 1'b0;

    ex_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .alusel_i   (alusel),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .hi_i       (hi_in),
        .lo_i       (lo_in),
        .flush_i    (flush),
        .wdata_o    (wdata_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_t e;
        logic [63:0] p;
        longint sa, sb;
        longint unsigned ua, ub;
        int sh;
        e = '{default: '0};
        sh = int'(a % 32);
        case (sel)
            c_sel_logic: case (op)
                c_op_or:  e.wdata = a | b;
                c_op_and: e.wdata = a & b;
                c_op_xor: e.wdata = a ^ b;
                c_op_nor: e.wdata = ~(a | b);
                default:  e.wdata = '0;
            endcase
            c_sel_shift: case (op)
                c_op_sll: e.wdata = b << sh;
                c_op_srl: e.wdata = b >> sh;
                c_op_sra: e.wdata = $signed(b) >>> sh;
                default:  e.wdata = '0;
            endcase
            c_sel_arith: case (op)
                c_op_add:  e.wdata = a + b;
                c_op_sub:  e.wdata = a - b;
                c_op_slt:  e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                c_op_sltu: e.wdata = (a < b) ? 32'd1 : 32'd0;
                default:   e.wdata = '0;
            endcase
            c_sel_move: case (op)
                c_op_mfhi: e.wdata = hi;
                c_op_mflo: e.wdata = lo;
                default:   e.wdata = '0;
            endcase
            default: e.wdata = '0;
        endcase
        case (op)
            c_op_mthi: begin e.whilo = 1'b1; e.hi = a;  e.lo = lo; end
            c_op_mtlo: begin e.whilo = 1'b1; e.hi = hi; e.lo = a;  end
            c_op_mult: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.whilo = 1'b1; e.hi = p[63:32]; e.lo = p[31:0];
            end
            c_op_multu: begin
                p = {32'd0, a} * {32'd0, b};
                e.whilo = 1'b1; e.hi = p[63:32]; e.lo = p[31:0];
            end
            c_op_div, c_op_divu: begin
                e.whilo  = 1'b1;
                e.stalls = (b == 0) ? 1 : W + 1;
                if (b == 0) begin
                    e.hi = '0; e.lo = '0;
                end else if (op == c_op_div) begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
                end else begin
                    ua = {32'd0, a}; ub = {32'd0, b};
                    e.lo = 32'(ua / ub); e.hi = 32'(ua % ub);
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: one expectation retires on every non-stalled, non-reset cycle.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_vec++;
            if (q.size() != 0 || to_flag) begin
                n_err++;
                $display("FAIL drain: pending=%0d timeout=%0b, want pending=0 timeout=0", q.size(), to_flag);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end else if (rst) begin
            stall_run = 0;
            n_vec++;
            if ({wdata_o, wd_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o} != '0) begin
                n_err++;
                $display("FAIL rst_zero: got wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h stall=%b, want all 0",
                         wdata_o, wd_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o);
            end
        end else if (stallreq_o) begin
            stall_run++;
        end else begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL out: unexpected result wdata=%h whilo=%b hi=%h lo=%h, want no result", wdata_o, whilo_o, hi_o, lo_o);
            end else begin
                e = q.pop_front();
                if (wdata_o !== e.wdata || wd_o !== e.wd || wreg_o !== e.wreg || whilo_o !== e.whilo ||
                    stall_run != e.stalls || (e.whilo && (hi_o !== e.hi || lo_o !== e.lo))) begin
                    n_err++;
                    $display("FAIL out[%0d]: got wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h stalls=%0d, want wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h stalls=%0d",
                             n_vec, wdata_o, wd_o, wreg_o, whilo_o, hi_o, lo_o, stall_run,
                             e.wdata, e.wd, e.wreg, e.whilo, e.hi, e.lo, e.stalls);
                end
            end
            stall_run = 0;
        end
    end

    // mode 0: run to completion; 1: flush after `at` stall cycles; 2: reset after `at` stall cycles
    task automatic run_op(input logic [7:0] op, input logic [2:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] wdv, input logic wregv,
                          input int mode, input int at, input bit scr);
        exp_t e;
        int n;
        aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = wdv; wreg = wregv;
        hi_in = $urandom; lo_in = $urandom; flush = 1'b0;
        e = model(op, sel, a, b, hi_in, lo_in);
        e.wd = wdv; e.wreg = wregv;
        if (mode == 0) q.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            if (!stallreq_o) break;
            n++;
            if (mode != 0 && n == at) break;
            if (n > 100) begin
                to_flag = 1'b1;
                $display("FAIL stall_timeout: got stall still high after %0d cycles, want release", n);
                break;
            end
            @(posedge clk); #1;
            if (scr) begin reg1 = $urandom; reg2 = $urandom; end
        end
        if (mode == 1 && n == at) begin
            @(posedge clk); #1;
            flush = 1'b1;
            e.whilo = 1'b0; e.stalls = at;
            q.push_back(e);
            @(negedge clk);
        end else if (mode == 2 && n == at) begin
            @(posedge clk); #1;
            rst = 1'b1;
            repeat (2) @(negedge clk);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        rst = 1'b0;
    endtask

    logic [10:0] tbl [16];

    initial begin
        logic [10:0] ent;
        logic [W-1:0] ra, rb;
        tbl = '{{c_sel_logic, c_op_or},   {c_sel_logic, c_op_and},  {c_sel_logic, c_op_xor},
                {c_sel_logic, c_op_nor},  {c_sel_shift, c_op_sll},  {c_sel_shift, c_op_srl},
                {c_sel_shift, c_op_sra},  {c_sel_arith, c_op_add},  {c_sel_arith, c_op_sub},
                {c_sel_arith, c_op_slt},  {c_sel_arith, c_op_sltu}, {c_sel_move, c_op_mfhi},
                {c_sel_nop, c_op_mult},   {c_sel_nop, c_op_divu},   {c_sel_nop, c_op_div},
                {3'b111, c_op_or}};
        aluop = c_op_div; reg1 = 32'd77; reg2 = 32'd5; wd = 5'd9; wreg = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_op(c_op_or,    c_sel_logic, 32'h0F0F0000, 32'h0000F0F0, 5'd3, 1'b1, 0, 0, 1'b0);
        run_op(c_op_mult,  c_sel_nop,   32'hFFFFFFFF, 32'd5,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_multu, c_sel_nop,   32'hFFFFFFFF, 32'd5,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_div,   c_sel_nop,   32'hFFFFFFF9, 32'd2,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_divu,  c_sel_nop,   32'd100,      32'd7,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_divu,  c_sel_nop,   32'd5,        32'd0,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_div,   c_sel_nop,   32'd1000,     32'd7,        5'd0, 1'b0, 1, 11, 1'b0);
        run_op(c_op_div,   c_sel_nop,   32'd1000,     32'hFFFFFFF9, 5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_div,   c_sel_nop,   32'd1234,     32'd11,       5'd0, 1'b0, 2, 6, 1'b0);
        run_op(c_op_divu,  c_sel_nop,   32'd9,        32'd3,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_div,   c_sel_nop,   32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_mthi,  c_sel_nop,   32'hA5A5A5A5, 32'd0,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_mtlo,  c_sel_nop,   32'h5A5A5A5A, 32'd0,        5'd0, 1'b0, 0, 0, 1'b0);
        run_op(c_op_mflo,  c_sel_move,  32'd0,        32'd0,        5'd7, 1'b1, 0, 0, 1'b0);
        run_op(c_op_sra,   c_sel_shift, 32'd31,       32'h80000000, 5'd8, 1'b1, 0, 0, 1'b0);
        run_op(8'hFF,      c_sel_logic, 32'hFFFF,     32'hFFFF,     5'd2, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            ent = tbl[$urandom_range(0, 15)];
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op(ent[7:0], ent[10:8], ra, rb, 5'($urandom), 1'($urandom), 0, 0, 1'b1);
        end
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, want summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
